// File: rtl/renode_apb_req_pkg.sv
`default_nettype none
// ============================================================================
// Module : renode_apb_req_pkg
// Brief  : Shared types and constants for the queued APB requester:
//          the transfer state encoding and the response-buffer depth.
// Rev    : 1.0 - initial release
// ============================================================================
package renode_apb_req_pkg;

    // APB transfer phases; a transfer is in flight in S_SETUP and S_ACCESS.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // Response buffer entries.
    localparam int unsigned c_RSP_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/renode_apb_req_fifo.sv
`default_nettype none
// ============================================================================
// Module : renode_apb_req_fifo
// Brief  : Generic synchronous FIFO, power-of-2 depth, head presented on
//          o_rdata. Push into a full FIFO and pop from an empty FIFO are
//          ignored; simultaneous push and pop leave the count unchanged.
// Ports  : clk, rst_n (async, active-low)
//          i_push / i_wdata  - write side
//          i_pop  / o_rdata  - read side (o_rdata = current head)
//          o_count           - number of stored entries
// Rev    : 1.0 - initial release
// ============================================================================
module renode_apb_req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_push,
    input  logic [WIDTH-1:0]                 i_wdata,
    input  logic                             i_pop,
    output logic [WIDTH-1:0]                 o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]       o_count
);

    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push = i_push && (r_count != c_FULL);
    assign w_pop  = i_pop  && (r_count != '0);

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/renode_apb_requester_queued.sv
`default_nettype none
// ============================================================================
// Module : renode_apb_requester_queued
// Brief  : APB3/APB4 requester with a request FIFO and a 2-entry response
//          buffer. Upstream valid/ready request and response channels,
//          downstream drives one APB completer; back-to-back transfers.
// Ports  : clk, rst_n (async, active-low)
//          req_valid/req_ready/req_write/req_addr/req_wdata/req_strb
//          rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout
//          paddr/psel/penable/pwrite/pwdata/pstrb/pprot (APB out)
//          pready/prdata/pslverr (APB in)
// Config : APB_REQ_TIMEOUT_EN - when defined, an ACCESS phase without pready
//          is aborted after TIMEOUT_CYCLES cycles with an err+timeout response.
// Rev    : 1.0 - initial release
// ============================================================================
module renode_apb_requester_queued
    import renode_apb_req_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned QUEUE_DEPTH    = 4,
    parameter logic [2:0]  PPROT_VALUE    = 3'b000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);

    localparam int unsigned c_STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned c_REQ_CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned c_RSP_CNT_W = $clog2(c_RSP_DEPTH + 1);
    localparam logic [c_REQ_CNT_W-1:0] c_REQ_FULL = c_REQ_CNT_W'(QUEUE_DEPTH);
    localparam logic [c_RSP_CNT_W-1:0] c_RSP_FULL = c_RSP_CNT_W'(c_RSP_DEPTH);
    localparam logic [c_RSP_CNT_W-1:0] c_RSP_ONE  = c_RSP_CNT_W'(1);

    generate
        if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
            $error("DATA_WIDTH must be 8, 16, 32 or 64");
        end
        if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_queue_depth
            $error("QUEUE_DEPTH must be a power of 2 and at least 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [c_STRB_W-1:0]   strb;
    } req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } rsp_t;

    state_t                 r_state;
    state_t                 w_state_next;
    req_t                   w_req_in;
    req_t                   w_req_head;
    rsp_t                   w_rsp_in;
    rsp_t                   w_rsp_head;
    logic [c_REQ_CNT_W-1:0] w_req_count;
    logic [c_RSP_CNT_W-1:0] w_rsp_count;
    logic [c_RSP_CNT_W-1:0] w_rsp_count_after_push;
    logic                   w_req_empty;
    logic                   w_req_push;
    logic                   w_req_pop;
    logic                   w_rsp_push;
    logic                   w_rsp_pop;
    logic                   w_tmo_hit;
    logic                   r_ready_en;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic [c_STRB_W-1:0]    r_pstrb;

    // ---------------------------------------------------------------- queues
    assign w_req_push = req_valid && req_ready;
    assign w_req_in   = '{write: req_write, addr: req_addr, wdata: req_wdata, strb: req_strb};

    renode_apb_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_req_push),
        .i_wdata (w_req_in),
        .i_pop   (w_req_pop),
        .o_rdata (w_req_head),
        .o_count (w_req_count)
    );

    renode_apb_req_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (c_RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_push),
        .i_wdata (w_rsp_in),
        .i_pop   (w_rsp_pop),
        .o_rdata (w_rsp_head),
        .o_count (w_rsp_count)
    );

    assign w_req_empty = (w_req_count == '0);
    assign w_rsp_pop   = rsp_valid && rsp_ready;
    // Response occupancy at the end of a completing ACCESS cycle (one push
    // plus any pop by the consumer in the same cycle).
    assign w_rsp_count_after_push = w_rsp_count + c_RSP_ONE - c_RSP_CNT_W'(w_rsp_pop);

    // -------------------------------------------------------------- timeout
`ifdef APB_REQ_TIMEOUT_EN
    localparam int unsigned c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [c_TMO_W-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_req_pop) begin
            r_timer <= '0;
        end else if (r_state == S_ACCESS && !pready) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // pready in the last allowed cycle still completes normally.
    assign w_tmo_hit = (r_state == S_ACCESS) && !pready && (r_timer == c_TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_pop    = 1'b0;
        w_rsp_push   = 1'b0;
        w_rsp_in     = '0;
        case (r_state)
            S_IDLE: begin
                if (!w_req_empty && w_rsp_count < c_RSP_FULL) begin
                    w_state_next = S_SETUP;
                    w_req_pop    = 1'b1;
                end
            end
            S_SETUP: begin
                w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    w_rsp_push     = 1'b1;
                    w_rsp_in.rdata = r_pwrite ? '0 : prdata;
                    w_rsp_in.err   = pslverr;
                    if (!w_req_empty && w_rsp_count_after_push <= c_RSP_ONE) begin
                        w_state_next = S_SETUP;
                        w_req_pop    = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_rsp_push       = 1'b1;
                    w_rsp_in.err     = 1'b1;
                    w_rsp_in.timeout = 1'b1;
                    w_state_next     = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- APB outputs
    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_paddr    <= '0;
            r_pwrite   <= 1'b0;
            r_pwdata   <= '0;
            r_pstrb    <= '0;
        end else begin
            r_ready_en <= 1'b1;
            r_psel     <= (w_state_next != S_IDLE);
            r_penable  <= (w_state_next == S_ACCESS);
            if (w_req_pop) begin
                r_paddr  <= w_req_head.addr;
                r_pwrite <= w_req_head.write;
                r_pwdata <= w_req_head.write ? w_req_head.wdata : '0;
                r_pstrb  <= w_req_head.write ? w_req_head.strb  : '0;
            end else if (w_state_next == S_IDLE) begin
                r_paddr  <= '0;
                r_pwrite <= 1'b0;
                r_pwdata <= '0;
                r_pstrb  <= '0;
            end
        end
    end

    assign paddr   = r_paddr;
    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign pwdata  = r_pwdata;
    assign pstrb   = r_pstrb;
    assign pprot   = PPROT_VALUE;

    // ------------------------------------------------------- upstream side
    // req_ready stays low until the first clock edge after reset release.
    assign req_ready   = r_ready_en && (w_req_count != c_REQ_FULL);
    assign rsp_valid   = (w_rsp_count != '0);
    assign rsp_rdata   = rsp_valid ? w_rsp_head.rdata   : '0;
    assign rsp_err     = rsp_valid ? w_rsp_head.err     : 1'b0;
    assign rsp_timeout = rsp_valid ? w_rsp_head.timeout : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_renode_apb_requester_queued.sv
`default_nettype none
// ============================================================================
// Module : tb_renode_apb_requester_queued
// Brief  : Self-checking bench for renode_apb_requester_queued: a table of
//          single-transfer vectors plus hand-timed multi-cycle sequences
//          (back-to-back queue, response back-pressure, error, timeout,
//          reset during ACCESS).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_renode_apb_requester_queued;

    localparam logic [31:0] c_K = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    renode_apb_requester_queued #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .QUEUE_DEPTH    (4),
        .PPROT_VALUE    (3'b000),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
    endtask

    // One isolated transfer: accepted at edge 0, SETUP in cycle 1,
    // ACCESS from cycle 2 for waits+1 cycles, response the cycle after.
    task automatic run_vec(input int idx, input vec_t v);
        check($sformatf("v%0d req_ready", idx), req_ready, 1);
        push_req(v.write, v.addr, v.wdata, v.strb);
        pready = 1'b0;
        tick();
        req_valid = 1'b0;
        check($sformatf("v%0d psel c0", idx), psel, 0);
        tick();
        check($sformatf("v%0d psel setup", idx), psel, 1);
        check($sformatf("v%0d penable setup", idx), penable, 0);
        check($sformatf("v%0d paddr", idx), paddr, v.addr);
        check($sformatf("v%0d pwrite", idx), pwrite, v.write);
        check($sformatf("v%0d pwdata", idx), pwdata, v.exp_pwdata);
        check($sformatf("v%0d pstrb", idx), pstrb, v.exp_pstrb);
        check($sformatf("v%0d pprot", idx), pprot, 0);
        for (int k = 0; k <= v.waits; k++) begin
            tick();
            check($sformatf("v%0d psel access%0d", idx, k), psel, 1);
            check($sformatf("v%0d penable access%0d", idx, k), penable, 1);
            check($sformatf("v%0d paddr access%0d", idx, k), paddr, v.addr);
            check($sformatf("v%0d rsp_valid access%0d", idx, k), rsp_valid, 0);
            pready  = (k == v.waits);
            prdata  = (k == v.waits) ? v.prdata : (32'hBAD0_0000 | k);
            pslverr = (k == v.waits) ? v.slverr : 1'b1;
        end
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        check($sformatf("v%0d psel done", idx), psel, 0);
        check($sformatf("v%0d penable done", idx), penable, 0);
        check($sformatf("v%0d rsp_valid", idx), rsp_valid, 1);
        check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d rsp_err", idx), rsp_err, v.exp_err);
        check($sformatf("v%0d rsp_timeout", idx), rsp_timeout, 0);
        tick();
        check($sformatf("v%0d rsp popped", idx), rsp_valid, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0BAD_0BAD, 1'b0,
                    32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234_5678, 1'b0,
                    32'h0, 4'h0, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 4'h5, 1, 32'h0000_0001, 1'b1,
                    32'hA5A5_5A5A, 4'h5, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0044, 32'h0000_1234, 4'h3, 0, 32'hCAFE_F00D, 1'b1,
                    32'h0, 4'h0, 32'hCAFE_F00D, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0080, 32'h0000_00FF, 4'h1, 2, 32'hFFFF_FFFF, 1'b0,
                    32'h0000_00FF, 4'h1, 32'h0, 1'b0};

        // ---- reset state
        #12;
        check("reset psel", psel, 0);
        check("reset penable", penable, 0);
        check("reset paddr", paddr, 0);
        check("reset pwdata", pwdata, 0);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset req_ready", req_ready, 0);
        #10;
        rst_n = 1'b1;
        #1;
        check("req_ready just after release", req_ready, 0);
        tick();
        check("req_ready one cycle after release", req_ready, 1);

        // ---- single-transfer vectors
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end

        // ---- back-to-back: 5 requests (W,R,W,R,W) queued behind a stalled
        // first transfer; then zero-wait streaming, responses in order.
        rsp_ready = 1'b1;
        pready    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("A req_ready push%0d", i), req_ready, 1);
            push_req((i % 2) == 0, 32'h100 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'(15 - i));
            tick();
        end
        req_valid = 1'b0;
        check("A req_ready full", req_ready, 0);
        check("A psel c4", psel, 1);
        check("A penable c4", penable, 1);
        check("A paddr c4", paddr, 32'h100);
        pready = 1'b1;
        prdata = paddr ^ c_K;
        for (int c = 0; c < 8; c++) begin
            int          j;
            int          t;
            logic [31:0] exp_rd;
            tick();
            prdata = paddr ^ c_K;
            t = 1 + c / 2;
            j = c / 2;
            check($sformatf("A psel c%0d", 5 + c), psel, 1);
            check($sformatf("A penable c%0d", 5 + c), penable, c % 2);
            check($sformatf("A paddr c%0d", 5 + c), paddr, 32'h100 + 32'(t * 4));
            if (c % 2 == 0) begin
                check($sformatf("A pwrite c%0d", 5 + c), pwrite, (t % 2) == 0);
                check($sformatf("A pwdata c%0d", 5 + c), pwdata,
                      ((t % 2) == 0) ? 32'h1111_0000 + 32'(t) : 32'h0);
                exp_rd = ((j % 2) == 0) ? 32'h0 : ((32'h100 + 32'(j * 4)) ^ c_K);
                check($sformatf("A rsp_valid rsp%0d", j), rsp_valid, 1);
                check($sformatf("A rsp_rdata rsp%0d", j), rsp_rdata, exp_rd);
            end else begin
                check($sformatf("A rsp_valid c%0d", 5 + c), rsp_valid, 0);
            end
            if (c == 0) check("A req_ready after pop", req_ready, 1);
        end
        tick();
        check("A psel end", psel, 0);
        check("A rsp_valid rsp4", rsp_valid, 1);
        check("A rsp_rdata rsp4", rsp_rdata, 0);
        pready = 1'b0;
        tick();
        check("A rsp drained", rsp_valid, 0);

        // ---- response back-pressure: 3 reads with rsp_ready=0; the first
        // read gets pslverr, the second must still complete cleanly.
        rsp_ready = 1'b0;
        pready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_req(1'b0, 32'h200 + 32'(i * 4), 32'hFFFF_FFFF, 4'hF);
            tick();
            prdata  = paddr ^ c_K;
            pslverr = (paddr == 32'h200);
        end
        req_valid = 1'b0;
        tick();
        prdata  = paddr ^ c_K;
        pslverr = (paddr == 32'h200);
        check("B psel c3", psel, 1);
        check("B penable c3", penable, 0);
        check("B paddr c3", paddr, 32'h204);
        check("B rsp_valid c3", rsp_valid, 1);
        check("B rsp_rdata r0", rsp_rdata, 32'h200 ^ c_K);
        check("B rsp_err r0", rsp_err, 1);
        check("B rsp_timeout r0", rsp_timeout, 0);
        tick();
        prdata  = paddr ^ c_K;
        pslverr = (paddr == 32'h200);
        check("B penable c4", penable, 1);
        for (int c = 5; c < 8; c++) begin
            tick();
            check($sformatf("B psel parked c%0d", c), psel, 0);
            check($sformatf("B rsp head c%0d", c), rsp_rdata, 32'h200 ^ c_K);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("B psel c8", psel, 0);
        check("B rsp_rdata r1", rsp_rdata, 32'h204 ^ c_K);
        check("B rsp_err r1", rsp_err, 0);
        tick();
        check("B psel c9", psel, 1);
        check("B penable c9", penable, 0);
        check("B paddr c9", paddr, 32'h208);
        tick();
        prdata  = paddr ^ c_K;
        pslverr = 1'b0;
        check("B penable c10", penable, 1);
        tick();
        check("B psel c11", psel, 0);
        check("B rsp head c11", rsp_rdata, 32'h204 ^ c_K);
        rsp_ready = 1'b1;
        tick();
        check("B rsp_rdata r2", rsp_rdata, 32'h208 ^ c_K);
        tick();
        check("B rsp drained", rsp_valid, 0);
        pready = 1'b0;

`ifdef APB_REQ_TIMEOUT_EN
        // ---- timeout after 8 ACCESS cycles without pready
        push_req(1'b1, 32'h400, 32'h0000_4444, 4'hF);
        tick();
        req_valid = 1'b0;
        tick();
        check("T psel setup", psel, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("T penable access%0d", k), penable, 1);
        end
        tick();
        check("T psel dropped", psel, 0);
        check("T penable dropped", penable, 0);
        check("T rsp_valid", rsp_valid, 1);
        check("T rsp_err", rsp_err, 1);
        check("T rsp_timeout", rsp_timeout, 1);
        check("T rsp_rdata", rsp_rdata, 0);
        tick();
        // pready in the 8th ACCESS cycle completes normally
        push_req(1'b0, 32'h404, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            pready = (k == 7);
            prdata = 32'h0000_0077;
        end
        tick();
        pready = 1'b0;
        check("T2 rsp_valid", rsp_valid, 1);
        check("T2 rsp_err", rsp_err, 0);
        check("T2 rsp_timeout", rsp_timeout, 0);
        check("T2 rsp_rdata", rsp_rdata, 32'h77);
        tick();
`endif

        // ---- reset during ACCESS with a second request still queued
        rsp_ready = 1'b1;
        pready    = 1'b0;
        push_req(1'b0, 32'h500, 32'h0, 4'h0);
        tick();
        push_req(1'b0, 32'h504, 32'h0, 4'h0);
        tick();
        req_valid = 1'b0;
        tick();
        check("R psel access", psel, 1);
        check("R penable access", penable, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("R psel in reset", psel, 0);
        check("R penable in reset", penable, 0);
        check("R paddr in reset", paddr, 0);
        check("R req_ready in reset", req_ready, 0);
        pready = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check("R req_ready at release", req_ready, 0);
        tick();
        check("R req_ready after release", req_ready, 1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("R psel idle%0d", c), psel, 0);
            check($sformatf("R rsp_valid idle%0d", c), rsp_valid, 0);
            tick();
        end
        pready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
